// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer family: FSM state encoding and default widths.
package counter_pkg;

    localparam int unsigned CNT_W_DEF = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by DIV: o_tick fires on every DIV-th cycle that i_en is high.
module tick_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    generate
        if (DIV <= 1) begin : g_passthru
            // No phase to hold: every enabled cycle is a tick.
            logic unused_ok;
            assign unused_ok = ^{clk, reset_n, i_clr};
            assign o_tick    = i_en;
        end else begin : g_div
            localparam int unsigned PW = $clog2(DIV);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;

            assign o_tick = i_en && (phase_q == PW'(DIV - 1));

            always_comb begin
                phase_d = phase_q;
                if (i_clr) begin
                    phase_d = '0;
                end else if (i_en) begin
                    phase_d = o_tick ? '0 : phase_q + PW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: valid/ready load, prescaled decrement, pause/abort, optional auto-reload.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV         = 1,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load_valid,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_load_ready,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic presc_en;
    logic presc_clr;
    logic tick;

    assign o_load_ready = (state_q == ST_IDLE) && !i_abort;
    assign accept       = i_load_valid && o_load_ready;

    // PAUSE with pause released counts as a live cycle, so a pause costs exactly its length.
    assign presc_en = is_busy(state_q) && !i_abort && !i_pause;

    tick_prescaler #(
        .DIV(DIV)
    ) u_presc (
        .clk    (clk),
        .reset_n(reset_n),
        .i_en   (presc_en),
        .i_clr  (presc_clr),
        .o_tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        presc_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    reload_d  = i_load_val;
                    presc_clr = 1'b1;
                    cnt_d     = i_load_val;
                    state_d   = (i_load_val != '0) ? ST_RUN : ST_DONE;
                end
            end

            ST_RUN, ST_PAUSE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (tick && (cnt_q != '0)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (!i_abort && (AUTO_RELOAD != 0) && (reload_q != '0)) begin
                    state_d   = ST_RUN;
                    cnt_d     = reload_q;
                    presc_clr = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = is_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timers (plain DIV=1, and DIV=4 with auto-reload) driven by directed loads.
module tb_countdown_timer;
    import counter_pkg::*;

    typedef struct {
        int         cyc;
        logic [6:0] cnt;
        logic       busy;
        logic       done;
        logic [1:0] st;
        logic       rdy;
        bit         chk_rdy;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int fails  = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   dq0[$];
    int   dq1[$];

    logic       v0, p0, a0, rdy0, busy0, done0;
    logic [6:0] val0, cnt0;
    logic [1:0] st0;
    logic       v1, p1, a1, rdy1, busy1, done1;
    logic [6:0] val1, cnt1;
    logic [1:0] st1;

    countdown_timer #(.CNT_W(7), .DIV(1), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_load_valid(v0), .i_load_val(val0),
        .o_load_ready(rdy0), .i_pause(p0), .i_abort(a0), .o_cnt(cnt0),
        .o_busy(busy0), .o_done(done0), .o_state(st0)
    );

    countdown_timer #(.CNT_W(7), .DIV(4), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_load_valid(v1), .i_load_val(val1),
        .o_load_ready(rdy1), .i_pause(p1), .i_abort(a1), .o_cnt(cnt1),
        .o_busy(busy1), .o_done(done1), .o_state(st1)
    );

    task automatic push(input int which, input int c, input int cnt, input state_t st,
                        input bit rdy, input bit chk);
        exp_t e;
        e.cyc     = c;
        e.cnt     = 7'(cnt);
        e.st      = st;
        e.busy    = (st == ST_RUN) || (st == ST_PAUSE);
        e.done    = (st == ST_DONE);
        e.rdy     = rdy;
        e.chk_rdy = chk;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic check_entry(input string nm, input exp_t e, input logic [6:0] cnt,
                               input logic busy, input logic done, input logic [1:0] st,
                               input logic rdy);
        bit bad;
        tests++;
        bad = (e.cyc != cyc) || (cnt !== e.cnt) || (busy !== e.busy) || (done !== e.done)
              || (st !== e.st) || (e.chk_rdy && (rdy !== e.rdy));
        if (bad) begin
            fails++;
            $display("FAIL %s cyc=%0d(exp %0d) cnt=%0d exp %0d busy=%b exp %b done=%b exp %b st=%0d exp %0d rdy=%b exp %b",
                     nm, cyc, e.cyc, cnt, e.cnt, busy, e.busy, done, e.done, st, e.st, rdy,
                     e.chk_rdy ? e.rdy : rdy);
        end
    endtask

    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cyc <= cyc)
            check_entry("dut0_state", q0.pop_front(), cnt0, busy0, done0, st0, rdy0);
        while (q1.size() > 0 && q1[0].cyc <= cyc)
            check_entry("dut1_state", q1.pop_front(), cnt1, busy1, done1, st1, rdy1);
        if (done0 === 1'b1) begin
            tests++;
            if (dq0.size() > 0 && dq0[0] == cyc) void'(dq0.pop_front());
            else begin
                fails++;
                $display("FAIL dut0_done_pulse at cyc=%0d, expected next at %0d", cyc,
                         dq0.size() > 0 ? dq0[0] : -1);
            end
        end
        if (done1 === 1'b1) begin
            tests++;
            if (dq1.size() > 0 && dq1[0] == cyc) void'(dq1.pop_front());
            else begin
                fails++;
                $display("FAIL dut1_done_pulse at cyc=%0d, expected next at %0d", cyc,
                         dq1.size() > 0 ? dq1[0] : -1);
            end
        end
    end

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int P;
        reset_n = 1'b0;
        {v0, p0, a0, v1, p1, a1} = '0;
        val0 = '0;
        val1 = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-count clears everything; ready returns after release
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd20;
        for (int k = 1; k <= 5; k++) push(0, P + k - 1, 21 - k, ST_RUN, 1'b0, 1'b1);
        push(0, P + 5, 0, ST_IDLE, 1'b0, 1'b0);
        push(0, P + 6, 0, ST_IDLE, 1'b0, 1'b0);
        push(0, P + 7, 0, ST_IDLE, 1'b1, 1'b1);
        step_to(P);     v0 = 1'b0;
        step_to(P + 5); reset_n = 1'b0;
        step_to(P + 7); reset_n = 1'b1;
        step_to(P + 9);

        // Load 5: 5..1 then DONE pulse; mid-run load request is ignored
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd5;
        for (int k = 1; k <= 5; k++) push(0, P + k - 1, 6 - k, ST_RUN, 1'b0, 1'b1);
        push(0, P + 5, 0, ST_DONE, 1'b0, 1'b1);
        push(0, P + 6, 0, ST_IDLE, 1'b1, 1'b1);
        dq0.push_back(P + 5);
        step_to(P);     v0 = 1'b0;
        step_to(P + 1); v0 = 1'b1; val0 = 7'd9;
        step_to(P + 2); v0 = 1'b0;
        step_to(P + 8);

        // Load 10, pause three cycles at count 8
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd10;
        for (int k = 1; k <= 3; k++)  push(0, P + k - 1, 11 - k, ST_RUN, 1'b0, 1'b1);
        for (int k = 4; k <= 6; k++)  push(0, P + k - 1, 8, ST_PAUSE, 1'b0, 1'b1);
        for (int k = 7; k <= 13; k++) push(0, P + k - 1, 14 - k, ST_RUN, 1'b0, 1'b1);
        push(0, P + 13, 0, ST_DONE, 1'b0, 1'b1);
        push(0, P + 14, 0, ST_IDLE, 1'b1, 1'b1);
        dq0.push_back(P + 13);
        step_to(P);     v0 = 1'b0;
        step_to(P + 2); p0 = 1'b1;
        step_to(P + 5); p0 = 1'b0;
        step_to(P + 16);

        // Load 100, abort at count 50; a load under abort is refused
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd100;
        for (int k = 1; k <= 51; k++) push(0, P + k - 1, 101 - k, ST_RUN, 1'b0, 1'b1);
        push(0, P + 51, 0, ST_IDLE, 1'b0, 1'b1);
        push(0, P + 52, 0, ST_IDLE, 1'b1, 1'b1);
        push(0, P + 53, 0, ST_IDLE, 1'b1, 1'b1);
        step_to(P);      v0 = 1'b0;
        step_to(P + 50); a0 = 1'b1;
        step_to(P + 51); v0 = 1'b1; val0 = 7'd7;
        step_to(P + 52); v0 = 1'b0; a0 = 1'b0;
        step_to(P + 55);

        // Load 0: immediate DONE, never busy
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd0;
        push(0, P,     0, ST_DONE, 1'b0, 1'b1);
        push(0, P + 1, 0, ST_IDLE, 1'b1, 1'b1);
        dq0.push_back(P);
        step_to(P);     v0 = 1'b0;
        step_to(P + 3);

        // Load 127: full range, no wrap after reaching zero
        P = cyc + 1;
        v0 = 1'b1; val0 = 7'd127;
        for (int k = 1; k <= 127; k++) push(0, P + k - 1, 128 - k, ST_RUN, 1'b0, 1'b1);
        push(0, P + 127, 0, ST_DONE, 1'b0, 1'b1);
        push(0, P + 128, 0, ST_IDLE, 1'b1, 1'b1);
        push(0, P + 129, 0, ST_IDLE, 1'b1, 1'b1);
        dq0.push_back(P + 127);
        step_to(P);     v0 = 1'b0;
        step_to(P + 131);

        // DIV=4 auto-reload of 3: DONE every 13 cycles until aborted
        P = cyc + 1;
        v1 = 1'b1; val1 = 7'd3;
        for (int s = 1; s <= 27; s += 13) begin
            for (int j = 0; j < 12; j++) push(1, P + s + j - 1, 3 - j / 4, ST_RUN, 1'b0, 1'b1);
            push(1, P + s + 11, 0, ST_DONE, 1'b0, 1'b1);
            dq1.push_back(P + s + 11);
        end
        for (int j = 0; j <= 6; j++) push(1, P + 39 + j, 3 - j / 4, ST_RUN, 1'b0, 1'b1);
        push(1, P + 46, 0, ST_IDLE, 1'b1, 1'b1);
        push(1, P + 47, 0, ST_IDLE, 1'b1, 1'b1);
        step_to(P);      v1 = 1'b0;
        step_to(P + 45); a1 = 1'b1;
        step_to(P + 46); a1 = 1'b0;
        step_to(P + 70);

        tests++;
        if (q0.size() != 0 || q1.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left q0=%0d q1=%0d dq0=%0d dq1=%0d, required all 0",
                     q0.size(), q1.size(), dq0.size(), dq1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
